// File: rtl/flit_deserializer_pkg.sv
// Shared NoC receive-path types: flit/checksum types, deserializer states and the flit checksum function.
package flit_deserializer_pkg;

  localparam int FLIT_WIDTH = 128;
  localparam int FLIT_BYTES = FLIT_WIDTH / 8;

  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef logic [15:0]           checksum_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } flit_deser_state_t;

  // Ones-complement of the wrapping sum of the seven payload words; this is the value carried in flit[15:0].
  function automatic checksum_t calc_checksum(input flit_t f);
    checksum_t sum;
    sum = '0;
    for (int w = 0; w < 7; w++) begin
      sum = sum + f[FLIT_WIDTH-1-16*w -: 16];
    end
    return ~sum;
  endfunction

endpackage

// File: rtl/flit_deserializer_checksum.sv
// Combinational flit checksum verifier (module flit_checksum) built on calc_checksum.
module flit_checksum
  import flit_deserializer_pkg::*;
(
  input  flit_t     flit_i,
  output checksum_t csum_o,
  output logic      good_o
);

  assign csum_o = calc_checksum(flit_i);
  assign good_o = (flit_i[15:0] == csum_o);

endmodule

// File: rtl/flit_deserializer.sv
// Assembles 16 UART bytes (MSB first) into a flit, checks it and offers it on a valid/ready output.
// Build option: define FLIT_DESER_CHECKSUM_EN to enable checksum verification and err_checksum.
module flit_deserializer
  import flit_deserializer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int BYTES_PER_FLIT = FLIT_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       flit_valid,
  input  logic       flit_ready,
  output flit_t      flit_o,
  output logic       err_overflow,
  output logic       err_checksum,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  flit_deser_state_t state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  flit_t             shift_q, shift_d;
  flit_t             flit_q, flit_d;
  logic              valid_q, valid_d;
  logic              csum_good;
  logic              err_ovf_c, err_tmo_c;

`ifdef FLIT_DESER_CHECKSUM_EN
  logic err_chk_c;

  flit_checksum u_checksum (
    .flit_i (shift_q),
    .csum_o (),
    .good_o (csum_good)
  );

  assign err_checksum = err_chk_c;
`else
  assign csum_good    = 1'b1;
  assign err_checksum = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      shift_q <= '0;
      flit_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
    end
  end

  // Bytes shift in at the bottom, so after 16 bytes byte 0 sits in the top byte lane.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    flit_d    = flit_q;
    valid_d   = valid_q;
    err_ovf_c = 1'b0;
    err_tmo_c = 1'b0;
`ifdef FLIT_DESER_CHECKSUM_EN
    err_chk_c = 1'b0;
`endif

    if (valid_q && flit_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          shift_d = {shift_q[FLIT_WIDTH-9:0], rx_data};
          cnt_d   = 5'd1;
          timer_d = '0;
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (rx_valid) begin
          shift_d = {shift_q[FLIT_WIDTH-9:0], rx_data};
          cnt_d   = cnt_q + 5'd1;
          timer_d = '0;
          if (cnt_q == 5'(BYTES_PER_FLIT - 1)) begin
            state_d = S_CHECK;
          end
        end else if (timer_q >= TW'(TIMEOUT_CYCLES - 1)) begin
          err_tmo_c = 1'b1;
          timer_d   = TW'(TIMEOUT_CYCLES);
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_CHECK: begin
`ifdef FLIT_DESER_CHECKSUM_EN
        if (!csum_good) begin
          err_chk_c = 1'b1;
        end else
`endif
        if (csum_good && (!valid_q || flit_ready)) begin
          flit_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          err_ovf_c = 1'b1;
        end

        // A byte arriving during the check cycle opens the next flit.
        if (rx_valid) begin
          shift_d = {shift_q[FLIT_WIDTH-9:0], rx_data};
          cnt_d   = 5'd1;
          timer_d = '0;
          state_d = S_RECV;
        end else begin
          cnt_d   = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  assign flit_valid   = valid_q;
  assign flit_o       = flit_q;
  assign err_overflow = err_ovf_c;
  assign err_timeout  = err_tmo_c;

endmodule
